// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Raster geometry for the 1440x900@60 display path (88.75 MHz).
//            Start/stop values are compares on the *current* count: a flag
//            changes on the edge that leaves the compared count.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 11;

  typedef logic [HCOUNT_W-1:0] hcount_t;
  typedef logic [VCOUNT_W-1:0] vcount_t;

  // Horizontal geometry (1440 visible, 1600 total)
  localparam hcount_t HCOUNT_MAX        = 11'd1599;
  localparam hcount_t HBLNK_START_FRONT = 11'd1439;  // hblnk high from 1440
  localparam hcount_t HSYNC_START       = 11'd1487;  // hsync high from 1488
  localparam hcount_t HSYNC_STOP        = 11'd1519;  // hsync last high at 1519

  // Vertical geometry (900 visible, 926 total)
  localparam vcount_t VCOUNT_MAX        = 11'd925;
  localparam vcount_t VBLNK_START_FRONT = 11'd899;   // vblnk high from 900
  localparam vcount_t VSYNC_START       = 11'd902;   // vsync high from 903
  localparam vcount_t VSYNC_STOP        = 11'd933;   // runs past frame end

  // Smaller of two counts; keeps a window from wrapping into the next frame.
  function automatic logic [10:0] min_cnt(input logic [10:0] a,
                                          input logic [10:0] b);
    return (a < b) ? a : b;
  endfunction

  localparam hcount_t HSYNC_STOP_CLAMP = min_cnt(HSYNC_STOP, HCOUNT_MAX);
  localparam vcount_t VSYNC_STOP_CLAMP = min_cnt(VSYNC_STOP, VCOUNT_MAX);

endpackage
`default_nettype wire

// File: rtl/vga_window.sv
`default_nettype none
// ============================================================================
// Module   : vga_window
// Purpose  : Registered set/clear window flag driven by equality compares on
//            the current count. Only moves on cycles where the count advances.
// Revision : 1.0 - initial release
// ============================================================================
module vga_window #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_start,
  input  logic [CNT_W-1:0] i_stop,
  input  logic             i_adv,
  output logic             o_flag
);

  logic r_flag;
  logic w_flag_nxt;

  // Stop wins over start; the clamped stop guarantees a clear at the wrap.
  always_comb begin
    w_flag_nxt = r_flag;
    if (i_adv) begin
      if (i_cnt == i_stop) begin
        w_flag_nxt = 1'b0;
      end else if (i_cnt == i_start) begin
        w_flag_nxt = 1'b1;
      end
    end
  end

  // Flag register, cleared by reset so no partial pulse survives a restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag <= 1'b0;
    end else begin
      r_flag <= w_flag_nxt;
    end
  end

  assign o_flag = r_flag;

endmodule
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Purpose  : Raster timing generator: pixel/line counters, blanking, sync,
//            display enable and line/frame start markers, all co-registered.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing
  import vga_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                hblnk,
  output logic                vblnk,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic                line_start,
  output logic                frame_start
);

  if ((HBLNK_START_FRONT >= HCOUNT_MAX) || (HSYNC_START >= HCOUNT_MAX) ||
      (VBLNK_START_FRONT >= VCOUNT_MAX) || (VSYNC_START >= VCOUNT_MAX))
  begin : g_geom_check
    $error("vga_pkg: a window start compare is not below its count maximum");
  end

  // r_run is low on the first edge after reset so that edge presents 0,0.
  logic    r_run;
  hcount_t r_hcount;
  vcount_t r_vcount;
  logic    r_de;
  logic    r_line_start;
  logic    r_frame_start;

  logic    w_h_wrap;
  logic    w_v_wrap;
  hcount_t w_hcount_nxt;
  vcount_t w_vcount_nxt;
  logic    w_hblnk_nxt;
  logic    w_vblnk_nxt;

  // Next counter values; everything registered is derived from these.
  always_comb begin
    w_h_wrap     = r_run && (r_hcount == HCOUNT_MAX);
    w_v_wrap     = w_h_wrap && (r_vcount == VCOUNT_MAX);
    w_hcount_nxt = r_hcount;
    w_vcount_nxt = r_vcount;
    if (!r_run) begin
      w_hcount_nxt = '0;
      w_vcount_nxt = '0;
    end else begin
      w_hcount_nxt = w_h_wrap ? '0 : r_hcount + 11'd1;
      if (w_h_wrap) begin
        w_vcount_nxt = w_v_wrap ? '0 : r_vcount + 11'd1;
      end
    end
    // Next blanking state, needed here so de lines up with the counters.
    w_hblnk_nxt = r_run && !w_h_wrap &&
                  (hblnk || (r_hcount == HBLNK_START_FRONT));
    w_vblnk_nxt = r_run && !w_v_wrap &&
                  (vblnk || (w_h_wrap && (r_vcount == VBLNK_START_FRONT)));
  end

  // Counters and markers share one register stage with the window flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run         <= 1'b0;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_de          <= !w_hblnk_nxt && !w_vblnk_nxt;
      r_line_start  <= (w_hcount_nxt == '0);
      r_frame_start <= (w_hcount_nxt == '0) && (w_vcount_nxt == '0);
    end
  end

  vga_window #(.CNT_W(HCOUNT_W)) u_hblnk (
    .clk     (clk),
    .rst     (rst),
    .i_cnt   (r_hcount),
    .i_start (HBLNK_START_FRONT),
    .i_stop  (HCOUNT_MAX),
    .i_adv   (r_run),
    .o_flag  (hblnk)
  );

  vga_window #(.CNT_W(HCOUNT_W)) u_hsync (
    .clk     (clk),
    .rst     (rst),
    .i_cnt   (r_hcount),
    .i_start (HSYNC_START),
    .i_stop  (HSYNC_STOP_CLAMP),
    .i_adv   (r_run),
    .o_flag  (hsync)
  );

  vga_window #(.CNT_W(VCOUNT_W)) u_vblnk (
    .clk     (clk),
    .rst     (rst),
    .i_cnt   (r_vcount),
    .i_start (VBLNK_START_FRONT),
    .i_stop  (VCOUNT_MAX),
    .i_adv   (w_h_wrap),
    .o_flag  (vblnk)
  );

  vga_window #(.CNT_W(VCOUNT_W)) u_vsync (
    .clk     (clk),
    .rst     (rst),
    .i_cnt   (r_vcount),
    .i_start (VSYNC_START),
    .i_stop  (VSYNC_STOP_CLAMP),
    .i_adv   (w_h_wrap),
    .o_flag  (vsync)
  );

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing
// Purpose  : Self-checking bench for vga_timing against a raster-position
//            model; vertical regions are reached by jumping the line counter
//            at a line end where all flags already agree with line 899.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

  logic        clk;
  logic        rst;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hblnk, vblnk, hsync, vsync, de, line_start, frame_start;

  vga_timing dut (
    .clk         (clk),
    .rst         (rst),
    .hcount      (hcount),
    .vcount      (vcount),
    .hblnk       (hblnk),
    .vblnk       (vblnk),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: raster position plus "outputs held at zero" (reset) state.
  int m_h    = 0;
  int m_v    = 0;
  bit m_zero = 1'b1;

  // Per-line / per-frame statistics taken from the DUT outputs.
  int hs_cnt     = 0;
  int hb_cnt     = 0;
  bit line_full  = 1'b0;
  int vs_lines   = 0;
  int vb_lines   = 0;
  int gap        = 0;
  bit gap_valid  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (model h=%0d v=%0d) at %0t",
               tag, obs, exp, m_h, m_v, $time);
    end
  endtask

  task automatic check_outputs();
    bit e_hb, e_hs, e_vb, e_vs, e_de, e_ls, e_fs;
    e_hb = !m_zero && (m_h >= 1440);
    e_hs = !m_zero && (m_h >= 1488) && (m_h <= 1519);
    e_vb = !m_zero && (m_v >= 900);
    e_vs = !m_zero && (m_v >= 903);
    e_de = !m_zero && !e_hb && !e_vb;
    e_ls = !m_zero && (m_h == 0);
    e_fs = e_ls && (m_v == 0);
    chk("hcount", {21'd0, hcount}, m_h);
    chk("vcount", {21'd0, vcount}, m_v);
    chk("flags{hb,vb,hs,vs,de,ls,fs}",
        {25'd0, hblnk, vblnk, hsync, vsync, de, line_start, frame_start},
        {25'd0, e_hb, e_vb, e_hs, e_vs, e_de, e_ls, e_fs});
  endtask

  // One clock: advance the model with the rst value the DUT sampled,
  // then check every output half a period later.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_zero = 1'b1;
      m_h    = 0;
      m_v    = 0;
    end else if (m_zero) begin
      m_zero = 1'b0;
    end else begin
      m_h++;
      if (m_h == 1600) begin
        m_h = 0;
        m_v++;
        if (m_v == 926) m_v = 0;
      end
    end
    @(negedge clk);
    check_outputs();
    if (m_zero) begin
      line_full = 1'b0;
      gap_valid = 1'b0;
    end else begin
      if (m_h == 0) begin
        line_full = 1'b1;
        hs_cnt    = 0;
        hb_cnt    = 0;
        vs_lines += int'(vsync);
        vb_lines += int'(vblnk);
      end
      hs_cnt += int'(hsync);
      hb_cnt += int'(hblnk);
      if ((m_h == 1599) && line_full) begin
        chk("hsync_clocks_per_line", hs_cnt, 32);
        chk("hblnk_clocks_per_line", hb_cnt, 160);
      end
      gap++;
      if (line_start) begin
        if (gap_valid) chk("line_period", gap, 1600);
        gap       = 0;
        gap_valid = 1'b1;
      end
    end
  endtask

  // Move to the last pixel of the current line, then relabel it line 899.
  task automatic jump_to_line_899();
    int k;
    k = 0;
    while ((m_h != 1599) && (k < 2000)) begin
      tick();
      k++;
    end
    if (m_h != 1599) begin
      chk("jump_align_timeout", 0, 1);
    end else begin
      force dut.r_vcount = 11'd899;
      #1;
      release dut.r_vcount;
      m_v = 899;
      #1;
      chk("jump_vcount", {21'd0, vcount}, 899);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;

    // Reset held for 5 clocks, then release.
    repeat (5) tick();
    chk("reset_de", {31'd0, de}, 0);
    rst = 1'b0;
    tick();
    chk("release_frame_start", {31'd0, frame_start}, 1);
    chk("release_line_start", {31'd0, line_start}, 1);
    chk("release_de", {31'd0, de}, 1);
    tick();
    chk("release_hcount_1", {21'd0, hcount}, 1);
    chk("release_pulses_low", {30'd0, line_start, frame_start}, 0);

    // Random run lengths interleaved with random-length resets.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(50, 800)) tick();
      rst = 1'b1;
      repeat ($urandom_range(1, 4)) tick();
      rst = 1'b0;
    end
    repeat ($urandom_range(1, 1599)) tick();

    // Into vertical blanking, then reset mid-frame inside both sync pulses.
    jump_to_line_899();
    k = 0;
    while (!((m_h == 1500) && (m_v == 910)) && (k < 25000)) begin
      tick();
      k++;
    end
    if ((m_h == 1500) && (m_v == 910)) begin
      chk("midframe_syncs_high", {30'd0, hsync, vsync}, 3);
    end else begin
      chk("midframe_reach_timeout", 0, 1);
    end
    rst = 1'b1;
    tick();
    chk("midframe_reset_all_zero",
        {10'd0, hcount, vcount, hblnk, vblnk, hsync, vsync, de, line_start,
         frame_start}, 0);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("midframe_release_frame_start", {31'd0, frame_start}, 1);
    repeat ($urandom_range(2, 700)) tick();

    // Through the bottom of the frame and the frame wrap.
    jump_to_line_899();
    vs_lines = 0;
    vb_lines = 0;
    k = 0;
    while (!frame_start && (k < 50000)) begin
      tick();
      k++;
    end
    if (frame_start) begin
      chk("vsync_lines_per_frame", vs_lines, 23);
      chk("vblnk_lines_per_frame", vb_lines, 26);
    end else begin
      chk("frame_wrap_timeout", 0, 1);
    end
    repeat (3200) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
